// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the serial binary-to-BCD converter
package bin2bcd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_NINE  = 4'h9;
   localparam logic [3:0] BCD_ZERO  = 4'h0;

   // Counter must hold the values 0..width.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bin2bcd_2digit_add3.sv
// rtl/bin2bcd_2digit_add3.sv - double-dabble nibble correction (add 3 when >= 5)
module bcd_add3 (
   input  logic [3:0] nibble,
   output logic [3:0] corrected
);

   // Inputs never exceed 9 inside the converter, so 4 bits cannot overflow.
   assign corrected = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin2bcd_2digit.sv
// rtl/bin2bcd_2digit.sv - serial double-dabble converter producing two BCD digits
// with start/busy/done handshake and an auto re-conversion mode.
module bin2bcd_2digit
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH         = 7,
   parameter bit BLANK_LEADING = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             auto,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [3:0]       tens,
   output logic [3:0]       units,
   output logic             ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int SR_W  = WIDTH + 12;
   localparam logic [3:0] TENS_RST = BLANK_LEADING ? BCD_BLANK : BCD_ZERO;

   state_t           state;
   state_t           state_next;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_corr;
   logic [SR_W-1:0]  sr_shift;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             shift_en;
   logic             finish;
   logic             last_shift;

   logic [3:0] u_corr;
   logic [3:0] t_corr;
   logic [3:0] h_corr;
   logic [3:0] res_h;
   logic [3:0] res_t;
   logic [3:0] res_u;
   logic       next_ovf;
   logic [3:0] next_tens;
   logic [3:0] next_units;

   // Register layout: {hundreds, tens, units, binary}.
   bcd_add3 u_add3_units (.nibble(sr[WIDTH+3:WIDTH]),    .corrected(u_corr));
   bcd_add3 u_add3_tens  (.nibble(sr[WIDTH+7:WIDTH+4]),  .corrected(t_corr));
   bcd_add3 u_add3_hund  (.nibble(sr[WIDTH+11:WIDTH+8]), .corrected(h_corr));

   assign sr_corr    = {h_corr, t_corr, u_corr, sr[WIDTH-1:0]};
   assign sr_shift   = {sr_corr[SR_W-2:0], 1'b0};
   assign last_shift = (cnt == CNT_W'(WIDTH - 1));

   assign res_h = sr_shift[WIDTH+11:WIDTH+8];
   assign res_t = sr_shift[WIDTH+7:WIDTH+4];
   assign res_u = sr_shift[WIDTH+3:WIDTH];

   always_comb begin
      next_ovf   = (res_h != BCD_ZERO);
      next_tens  = res_t;
      next_units = res_u;
      if (next_ovf) begin
         next_tens  = BCD_NINE;
         next_units = BCD_NINE;
      end else if (BLANK_LEADING && (res_t == BCD_ZERO)) begin
         next_tens = BCD_BLANK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Auto restart keys off the registered done pulse, so it also lands in the done cycle.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      shift_en   = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start || (auto && done)) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last_shift) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         tens  <= TENS_RST;
         units <= BCD_ZERO;
      end else begin
         done <= finish;
         if (load) begin
            sr  <= {12'd0, bin};
            cnt <= '0;
         end else if (shift_en) begin
            sr  <= sr_shift;
            cnt <= cnt + CNT_W'(1);
         end
         if (finish) begin
            ovf   <= next_ovf;
            tens  <= next_tens;
            units <= next_units;
         end
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: doc/bin2bcd_2digit.md
Name: bin2bcd_2digit

Overview:
Sequential binary-to-BCD converter (serial double-dabble) that feeds the two-digit multiplexed 7-segment display stage. It converts a WIDTH-bit unsigned binary value into a tens digit and a units digit. The display stage then decodes these digits to segments and multiplexes them. A start/busy/done handshake is provided, plus an auto mode that re-converts continuously for a live display refresh.

Parameters:
WIDTH, 7, bit width of binary input; legal range 4..9 (internal hundreds nibble covers up to 999)
BLANK_LEADING, 0, 1 = replace a zero tens digit with blank code 4'hF when the value is below 10

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only when not busy
auto  input  1  1 = restart automatically after each completion
bin  input  WIDTH  unsigned binary value, sampled on the accepting edge
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; tens/units/ovf valid and updated in the same cycle
tens  output  4  BCD tens digit (0..9, or 4'hF when blanked)
units  output  4  BCD units digit (0..9)
ovf  output  1  latched value exceeded 99; digits saturate to 9,9

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, synchronous release):
  - state = IDLE, busy = 0, done = 0, ovf = 0.
  - tens = 0, or 4'hF if BLANK_LEADING = 1.
  - units = 0. Shift register and counter = 0.
- States: IDLE, SHIFT.
- IDLE: accept on start = 1, or auto = 1 while done = 1.
  - Accepting edge E0: latch bin into the low bits of the shift register, clear the BCD nibbles (hundreds, tens, units), count = 0, go to SHIFT, busy = 1.
- SHIFT: on each edge, every BCD nibble >= 5 gets +3 first, then the whole register shifts left by 1; count++.
  - The edge performing shift number WIDTH (edge E_WIDTH) returns to IDLE and clears busy.
  - On that same edge, register the outputs:
    - ovf = (hundreds != 0).
    - If ovf: tens = 9, units = 9.
    - Else: tens/units from the corrected nibbles, with blanking applied if BLANK_LEADING and tens == 0.
  - Set done = 1 for exactly one cycle.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the start-sampling edge (7 for the default).
- Throughput: a new start is accepted in the done cycle itself, so back-to-back conversions take one per WIDTH+1 cycles.
- start while busy: ignored and not queued. bin changes while busy have no effect.
- Outputs hold their last values between done pulses. The display sees stable digits during conversion.
- Simultaneous start and auto in the done cycle: a single conversion is accepted.
- Reset mid-SHIFT: immediate abort to the reset values; no done pulse.
- Arithmetic: each nibble correction is 4-bit; no carry out beyond the hundreds nibble is possible for WIDTH <= 9.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the constants BCD_BLANK = 4'hF and BCD_NINE = 4'h9;
  - the counter width, clog2(WIDTH+1).
- One natural combinational sub-module: bcd_add3, a 4-bit nibble correction (in >= 5 ? in + 3 : in), instantiated three times (units, tens, hundreds).

Test Plan:
- Basic: reset release, then start for 1 cycle with bin = 42 -> busy for 7 cycles, then done pulse with tens = 4, units = 2, ovf = 0; outputs hold afterwards.
- Boundary: bin = 99 -> 9,9, ovf = 0. bin = 100 -> 9,9, ovf = 1. bin = 127 -> 9,9, ovf = 1. bin = 0 -> 0,0.
- Blanking: BLANK_LEADING = 1 with bin = 5 -> tens = 4'hF, units = 5. bin = 10 -> tens = 1, units = 0. Reset value of tens is 4'hF.
- Busy collision: start with 42; pulse start with bin = 77 at cycle 3 -> result still 4,2 and only one done. Then start with 77 in the done cycle -> next done 8 cycles later with 7,7.
- Auto mode: auto = 1, single start, bin stepping 10 -> 11 -> 12 between conversions -> done every 8 cycles with 1,0 / 1,1 / 1,2; drop auto -> stops after the current conversion.
- Reset mid-op: start with bin = 55, assert rst_n low at cycle 4 -> busy = 0, done never pulses, digits at reset values. Start with 55 after release -> 5,5.
